// File: rtl/alu_input_ctrl_pkg.sv
// Shared types and widths for the ALU input-conditioning slice.
package alu_input_pkg;

  localparam int WORD_W = 32;
  localparam int OP_W   = 4;
  localparam int HALF_W = 16;
  localparam int KEY_W  = 4;
  localparam int SW_W   = 18;

  typedef logic [WORD_W-1:0] word_t;

  // Upper-half fill patterns selected by SW[16].
  typedef enum logic [HALF_W-1:0] {
    FILL_ZERO = 16'h0000,
    FILL_ONES = 16'hFFFF
  } fill_t;

  // Build a 32-bit operand from the fill select bit and the low half.
  function automatic word_t make_operand(input logic fill_sel, input logic [HALF_W-1:0] low);
    fill_t fill;
    fill = fill_sel ? FILL_ONES : FILL_ZERO;
    return {fill, low};
  endfunction

endpackage

// File: rtl/alu_input_ctrl_if.sv
// Pin-side and ALU-side signals of the input-conditioning stage.
// master: the conditioning stage; slave: board / ALU side.
interface alu_input_ctrl_if;
  import alu_input_pkg::*;

  logic [KEY_W-1:0] KEY;
  logic [SW_W-1:0]  SW;
  logic [OP_W-1:0]  aluop;
  word_t            portA;
  word_t            portB;
  logic             load_a;
  logic             load_b;

  modport master (input KEY, SW, output aluop, portA, portB, load_a, load_b);
  modport slave  (output KEY, SW, input aluop, portA, portB, load_a, load_b);

endinterface

// File: rtl/alu_input_ctrl_debounce_bit.sv
// Single-bit debouncer: stable state plus a counter of consecutive
// differing cycles. rise/fall are asserted in the cycle before the edge
// on which out changes, so consumers registering them update on that edge.
module debounce_bit #(
  parameter int unsigned CYCLES    = 500000,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  // Count while the input disagrees with the stable state; flip at the limit.
  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    flip  = 1'b0;
    if (in != out_q) begin
      if (cnt_q == CNT_LAST) begin
        flip  = 1'b1;
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State register with synchronous reset to the released level.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      out_q <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out  = out_q;
  assign rise = flip & ~out_q;
  assign fall = flip & out_q;

endmodule

// File: rtl/alu_input_ctrl.sv
// ALU input conditioning: synchronize and debounce KEY/SW, drive aluop,
// portA/portB and one-cycle load strobes.
// Optional macro ALU_INPUT_OP_LATCH_EN: aluop bits toggle on debounced
// key presses instead of following the key levels.
module alu_input_ctrl
  import alu_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input logic              CLOCK_50,
  input logic              RESET,
  alu_input_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [KEY_W-1:0] key_stable, key_rise, key_fall;

  logic [SW_W-1:0]  sw_cand_q, sw_cand_d, sw_comm_q, sw_comm_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  word_t            port_a_q, port_a_d, port_b_q, port_b_d;
  logic             load_a_q, load_a_d, load_b_q, load_b_d;

  // Two-flop synchronizer stages.
  always_comb begin
    key_s1_d = bus.KEY;
    key_s2_d = key_s1_q;
    sw_s1_d  = bus.SW;
    sw_s2_d  = sw_s1_q;
  end

  // Synchronizer registers: keys reset released, switches reset low.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_s1_q <= '1;
      key_s2_q <= '1;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
    end
  end

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    debounce_bit #(
      .CYCLES   (DEBOUNCE_CYCLES),
      .RESET_VAL(1'b1)
    ) u_db (
      .CLOCK_50(CLOCK_50),
      .RESET   (RESET),
      .in      (key_s2_q[i]),
      .out     (key_stable[i]),
      .rise    (key_rise[i]),
      .fall    (key_fall[i])
    );
  end

  // Whole-vector switch debounce. The candidate always trails the synced
  // vector by one cycle, so the commit fires when the counter steps onto
  // its last value; that lands DEBOUNCE_CYCLES after the synced change.
  always_comb begin
    sw_cand_d = sw_cand_q;
    sw_cnt_d  = sw_cnt_q;
    sw_comm_d = sw_comm_q;
    port_a_d  = port_a_q;
    port_b_d  = port_b_q;
    load_a_d  = 1'b0;
    load_b_d  = 1'b0;
    if (sw_s2_q != sw_cand_q) begin
      sw_cand_d = sw_s2_q;
      sw_cnt_d  = '0;
    end else if (sw_cnt_q != CNT_LAST) begin
      sw_cnt_d = sw_cnt_q + 1'b1;
      if (sw_cnt_q == CNT_PRE && sw_cand_q != sw_comm_q) begin
        sw_comm_d = sw_cand_q;
        if (sw_cand_q[SW_W-1]) begin
          port_b_d = make_operand(sw_cand_q[HALF_W], sw_cand_q[HALF_W-1:0]);
          load_b_d = 1'b1;
        end else begin
          port_a_d = make_operand(sw_cand_q[HALF_W], sw_cand_q[HALF_W-1:0]);
          load_a_d = 1'b1;
        end
      end
    end
  end

  // Switch debouncer and operand registers.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sw_cand_q <= '0;
      sw_cnt_q  <= '0;
      sw_comm_q <= '0;
      port_a_q  <= '0;
      port_b_q  <= '0;
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
    end else begin
      sw_cand_q <= sw_cand_d;
      sw_cnt_q  <= sw_cnt_d;
      sw_comm_q <= sw_comm_d;
      port_a_q  <= port_a_d;
      port_b_q  <= port_b_d;
      load_a_q  <= load_a_d;
      load_b_q  <= load_b_d;
    end
  end

`ifdef ALU_INPUT_OP_LATCH_EN
  logic [OP_W-1:0] aluop_q, aluop_d;
  logic            unused_key;

  // Sticky opcode: each debounced press toggles its bit.
  always_comb begin
    aluop_d = aluop_q ^ key_fall;
  end

  // Opcode register.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) aluop_q <= '0;
    else       aluop_q <= aluop_d;
  end

  assign unused_key = ^{key_rise, key_stable};
  assign bus.aluop  = aluop_q;
`else
  logic unused_key;
  assign unused_key = ^{key_rise, key_fall};
  assign bus.aluop  = ~key_stable;
`endif

  assign bus.portA  = port_a_q;
  assign bus.portB  = port_b_q;
  assign bus.load_a = load_a_q;
  assign bus.load_b = load_b_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Self-checking bench for alu_input_ctrl with a short debounce window.
module tb_alu_input_ctrl;
  import alu_input_pkg::*;

  localparam int unsigned DB   = 4;
  localparam int unsigned HIST = DB + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_input_ctrl_if bus ();

  alu_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .bus     (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: raw input history (newest at index 0). The synced
  // value seen at an edge is the raw value from two edges earlier.
  logic [3:0]  kh[$];
  logic [17:0] sh[$];
  logic [3:0]  m_stable, m_op;
  logic [17:0] m_comm;
  word_t       m_a, m_b;
  logic        m_la, m_lb;

  typedef struct {
    logic [3:0]  key;
    logic [17:0] sw;
    int          hold;
    logic [3:0]  exp_op;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    logic all_diff, held;
    logic [17:0] v;
    word_t w;
    if (rst) begin
      kh.delete();
      sh.delete();
      for (int i = 0; i < int'(HIST); i++) begin
        kh.push_back(4'hF);
        sh.push_back('0);
      end
      m_stable = 4'hF;
      m_op = '0;
      m_comm = '0;
      m_a = '0;
      m_b = '0;
      m_la = 1'b0;
      m_lb = 1'b0;
    end else begin
      kh.push_front(bus.KEY);
      sh.push_front(bus.SW);
      void'(kh.pop_back());
      void'(sh.pop_back());
      // A key flips once its synced level has disagreed for DB straight edges.
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < int'(DB); j++)
          if (kh[2+j][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) begin
`ifdef ALU_INPUT_OP_LATCH_EN
          if (m_stable[b]) m_op[b] = ~m_op[b];
`endif
          m_stable[b] = ~m_stable[b];
        end
      end
`ifndef ALU_INPUT_OP_LATCH_EN
      m_op = ~m_stable;
`endif
      // Switch vector commits when a new value has been held DB edges.
      m_la = 1'b0;
      m_lb = 1'b0;
      v = sh[2];
      held = 1'b1;
      for (int j = 1; j < int'(DB); j++)
        if (sh[2+j] != v) held = 1'b0;
      if (held && sh[2+DB] != v && v != m_comm) begin
        m_comm = v;
        w = {v[16] ? 16'hFFFF : 16'h0000, v[15:0]};
        if (v[17]) begin m_b = w; m_lb = 1'b1; end
        else       begin m_a = w; m_la = 1'b1; end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_aluop"},  32'(bus.aluop), 32'(m_op));
    chk({nm, "_portA"},  bus.portA, m_a);
    chk({nm, "_portB"},  bus.portB, m_b);
    chk({nm, "_load_a"}, 32'(bus.load_a), 32'(m_la));
    chk({nm, "_load_b"}, 32'(bus.load_b), 32'(m_lb));
  endtask

  initial begin
    vec_t vecs[7];
    int cnt_a, cnt_b, strobes;
    logic [3:0] op_seen;
    logic [3:0] exp_op;
    int hold;

    vecs[0] = '{4'hF, 18'h0_1234, 10, 4'h0, 32'h0000_1234, 32'h0000_0000};
    vecs[1] = '{4'hF, 18'h3_8000, 10, 4'h0, 32'h0000_1234, 32'hFFFF_8000};
    vecs[2] = '{4'hE, 18'h3_8000, 10, 4'h1, 32'h0000_1234, 32'hFFFF_8000};
    vecs[3] = '{4'h6, 18'h1_00AA, 10, 4'h9, 32'hFFFF_00AA, 32'hFFFF_8000};
    vecs[4] = '{4'h6, 18'h3_00AA, 10, 4'h9, 32'hFFFF_00AA, 32'hFFFF_00AA};
    vecs[5] = '{4'h0, 18'h3_00AA, 10, 4'hF, 32'hFFFF_00AA, 32'hFFFF_00AA};
    vecs[6] = '{4'hF, 18'h0_0000, 10, 4'h0, 32'h0000_0000, 32'hFFFF_00AA};

    // Reset
    rst = 1'b1;
    bus.KEY = 4'hF;
    bus.SW = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_aluop", 32'(bus.aluop), 0);
    chk("rst_portA", bus.portA, 0);
    chk("rst_portB", bus.portB, 0);
    chk("rst_load_a", 32'(bus.load_a), 0);
    chk("rst_load_b", 32'(bus.load_b), 0);
    strobes = 0;
    repeat (20) begin
      step();
      if (bus.load_a || bus.load_b) strobes++;
    end
    chk("idle_strobes", 32'(strobes), 0);

    // Operand A load timing
    bus.SW = 18'h0_1234;
    repeat (5) step();
    chk("a_early_portA", bus.portA, 0);
    chk("a_early_load_a", 32'(bus.load_a), 0);
    step();
    chk("a_commit_portA", bus.portA, 32'h0000_1234);
    chk("a_commit_load_a", 32'(bus.load_a), 1);
    chk("a_commit_portB", bus.portB, 0);
    chk("a_commit_load_b", 32'(bus.load_b), 0);
    step();
    chk("a_after_load_a", 32'(bus.load_a), 0);
    chk("a_after_portA", bus.portA, 32'h0000_1234);
    repeat (5) step();

    // Operand B with fill
    bus.SW = 18'h3_8000;
    cnt_a = 0;
    cnt_b = 0;
    repeat (12) begin
      step();
      if (bus.load_a) cnt_a++;
      if (bus.load_b) cnt_b++;
    end
    chk("b_portB", bus.portB, 32'hFFFF_8000);
    chk("b_load_b_count", 32'(cnt_b), 1);
    chk("b_load_a_count", 32'(cnt_a), 0);
    chk("b_portA_held", bus.portA, 32'h0000_1234);

    // Key glitch rejection, then an accepted press
    bus.KEY = 4'hE;
    repeat (3) step();
    bus.KEY = 4'hF;
    op_seen = '0;
    repeat (10) begin
      step();
      op_seen |= bus.aluop;
    end
    chk("glitch_aluop", 32'(op_seen), 0);
    bus.KEY = 4'hE;
    repeat (5) step();
    chk("press_early_aluop", 32'(bus.aluop), 0);
    step();
    chk("press_aluop", 32'(bus.aluop), 32'h1);
    repeat (4) step();
    bus.KEY = 4'hF;
    repeat (8) step();
`ifdef ALU_INPUT_OP_LATCH_EN
    chk("release_aluop", 32'(bus.aluop), 32'h1);
`else
    chk("release_aluop", 32'(bus.aluop), 32'h0);
`endif

    // Reset in the middle of a switch debounce
    bus.SW = 18'h0_00FF;
    step();
    step();
    rst = 1'b1;
    bus.SW = '0;
    step();
    step();
    rst = 1'b0;
    strobes = 0;
    repeat (12) begin
      step();
      if (bus.load_a || bus.load_b) strobes++;
    end
    chk("midrst_strobes", 32'(strobes), 0);
    chk("midrst_portA", bus.portA, 0);
    chk("midrst_portB", bus.portB, 0);
    chk("midrst_aluop", 32'(bus.aluop), 0);

`ifdef ALU_INPUT_OP_LATCH_EN
    // Sticky opcode built one key at a time
    bus.KEY = 4'hB; repeat (8) step(); chk("latch_k2_press1", 32'(bus.aluop), 32'h4);
    bus.KEY = 4'hF; repeat (8) step(); chk("latch_k2_rel1", 32'(bus.aluop), 32'h4);
    bus.KEY = 4'hB; repeat (8) step(); chk("latch_k2_press2", 32'(bus.aluop), 32'h0);
    bus.KEY = 4'hF; repeat (8) step(); chk("latch_k2_rel2", 32'(bus.aluop), 32'h0);
    bus.KEY = 4'hE; repeat (8) step(); chk("latch_k0_press", 32'(bus.aluop), 32'h1);
    bus.KEY = 4'hF; repeat (8) step(); chk("latch_k0_rel", 32'(bus.aluop), 32'h1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("latch_rst_aluop", 32'(bus.aluop), 0);
`endif

    // Table-driven vectors; entry 3 also checks a key and switch commit
    // landing on the same edge.
    for (int i = 0; i < 7; i++) begin
      bus.KEY = vecs[i].key;
      bus.SW = vecs[i].sw;
      if (i == 3) begin
        repeat (5) step();
        chk("same_edge_early_load_a", 32'(bus.load_a), 0);
        step();
        chk("same_edge_load_a", 32'(bus.load_a), 1);
        chk("same_edge_aluop", 32'(bus.aluop), 32'(m_op));
`ifndef ALU_INPUT_OP_LATCH_EN
        chk("same_edge_aluop_const", 32'(bus.aluop), 32'h9);
`endif
        repeat (vecs[i].hold - 6) step();
      end else begin
        repeat (vecs[i].hold) step();
      end
`ifdef ALU_INPUT_OP_LATCH_EN
      exp_op = m_op;
`else
      exp_op = vecs[i].exp_op;
`endif
      chk($sformatf("vec%0d_aluop", i), 32'(bus.aluop), 32'(exp_op));
      chk($sformatf("vec%0d_portA", i), bus.portA, vecs[i].exp_a);
      chk($sformatf("vec%0d_portB", i), bus.portB, vecs[i].exp_b);
    end

    // Randomized stimulus against the reference model
    for (int n = 0; n < 300; n++) begin
      bus.KEY = 4'($urandom);
      bus.SW = {1'($urandom), 1'($urandom), 14'h0, 2'($urandom)};
      rst = ($urandom_range(0, 39) == 0);
      hold = int'($urandom_range(1, 9));
      for (int c = 0; c < hold; c++) begin
        step();
        rst = 1'b0;
        chk_model("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
